// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if -- bus bundle between two requesters, the arbiter and the SRAM.
//
// Requester side : req0/1, we0/1, addr0/1, wdata0/1 -> arbiter
//                  gnt0/1, rvalid0/1, rdata0/1      <- arbiter
// SRAM side      : sram_wri, sram_rd, sram_add, sram_din -> SRAM
//                  sram_dout                              <- SRAM
// Status         : busy (clear sequence running)
//
// Modports: slave = arbiter view, master = requesters + SRAM view.
interface sram_arbiter_if;
   logic       req0, req1;
   logic       we0, we1;
   logic [2:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1;
   logic       rvalid0, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic       sram_wri, sram_rd;
   logic [2:0] sram_add;
   logic [7:0] sram_din;
   logic [7:0] sram_dout;
   logic       busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             sram_wri, sram_rd, sram_add, sram_din, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             sram_wri, sram_rd, sram_add, sram_din, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter -- two-port round-robin arbiter/sequencer for an 8x8 SRAM.
//
// Ports:
//   clok : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sram_arbiter_if.slave (requester handshake, SRAM port, busy)
//
// Each accepted request takes one ACCESS cycle (gnt pulse + SRAM strobe);
// reads add a RESP cycle in which sram_dout is captured, and rvalid pulses
// in the following cycle. Ties go to the priority pointer, which always
// flips to the requester that did not win.
//
// Optional feature macro: SRAM_ARB_CLEAR_EN -- after every reset the CLR
// state writes 8'h00 to words 0..7 (busy=1, requests ignored) before IDLE.
module sram_arbiter (
   input  logic          clok,
   input  logic          rst,
   sram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {CLR, IDLE, ACCESS, RESP} state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;       // requester favoured on a tie
   logic             id_q, id_d;         // winner of the current access
   logic [2:0]       add_q, add_d;
   logic [7:0]       din_q, din_d;
   logic             wri_q, wri_d;
   logic             rd_q, rd_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       rvalid_q, rvalid_d;
   logic [1:0][7:0]  rdata_q, rdata_d;
   logic [1:0]       req_v;
   logic             win, win_we;
`ifdef SRAM_ARB_CLEAR_EN
   logic [2:0]       clr_cnt_q, clr_cnt_d;
`endif

   assign req_v = {bus.req1, bus.req0};

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      add_d    = add_q;
      din_d    = din_q;
      wri_d    = 1'b0;
      rd_d     = 1'b0;
      gnt_d    = 2'b00;
      rvalid_d = 2'b00;
      rdata_d  = rdata_q;
      win      = 1'b0;
      win_we   = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
`endif
      case (state_q)
`ifdef SRAM_ARB_CLEAR_EN
         CLR: begin
            clr_cnt_d = clr_cnt_q + 3'd1;
            if (clr_cnt_q == 3'd7) state_d = IDLE;
         end
`endif
         IDLE: begin
            if (|req_v) begin
               // lone requester wins outright; on a tie the pointer decides
               win      = (req_v == 2'b11) ? ptr_q : req_v[1];
               win_we   = win ? bus.we1 : bus.we0;
               id_d     = win;
               ptr_d    = ~win;
               gnt_d[win] = 1'b1;
               add_d    = win ? bus.addr1  : bus.addr0;
               din_d    = win ? bus.wdata1 : bus.wdata0;
               wri_d    = win_we;
               rd_d     = ~win_we;
               state_d  = ACCESS;
            end
         end
         ACCESS: state_d = rd_q ? RESP : IDLE;
         RESP: begin
            // SRAM output is valid this cycle (registered one after rd)
            rvalid_d[id_q] = 1'b1;
            rdata_d[id_q]  = bus.sram_dout;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clok) begin
      if (rst) begin
`ifdef SRAM_ARB_CLEAR_EN
         state_q   <= CLR;
         clr_cnt_q <= 3'd0;
`else
         state_q   <= IDLE;
`endif
         ptr_q    <= 1'b0;
         id_q     <= 1'b0;
         add_q    <= 3'd0;
         din_q    <= 8'h00;
         wri_q    <= 1'b0;
         rd_q     <= 1'b0;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
      end else begin
`ifdef SRAM_ARB_CLEAR_EN
         clr_cnt_q <= clr_cnt_d;
`endif
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         add_q    <= add_d;
         din_q    <= din_d;
         wri_q    <= wri_d;
         rd_q     <= rd_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.gnt0    = gnt_q[0];
   assign bus.gnt1    = gnt_q[1];
   assign bus.rvalid0 = rvalid_q[0];
   assign bus.rvalid1 = rvalid_q[1];
   assign bus.rdata0  = rdata_q[0];
   assign bus.rdata1  = rdata_q[1];
   assign bus.sram_rd = rd_q;

`ifdef SRAM_ARB_CLEAR_EN
   // clear writes are driven straight from the state so that all 8 words
   // are covered in the 8 busy cycles
   assign bus.sram_wri = (state_q == CLR) ? 1'b1      : wri_q;
   assign bus.sram_add = (state_q == CLR) ? clr_cnt_q : add_q;
   assign bus.sram_din = (state_q == CLR) ? 8'h00     : din_q;
   assign bus.busy     = (state_q == CLR);
`else
   assign bus.sram_wri = wri_q;
   assign bus.sram_add = add_q;
   assign bus.sram_din = din_q;
   assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- directed self-checking bench for sram_arbiter.
// Includes a behavioural 8x8 SRAM (data_out registered one cycle after rd).
module tb_sram_arbiter;

   logic clok = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_pass = 0;
   int   overlap = 0;

   sram_arbiter_if bus ();

   sram_arbiter dut (.clok(clok), .rst(rst), .bus(bus.slave));

   always #5 clok = ~clok;

   logic [7:0] mem [8];
   always @(posedge clok) begin
      if (bus.sram_wri) mem[bus.sram_add] <= bus.sram_din;
      if (bus.sram_rd)  bus.sram_dout <= mem[bus.sram_add];
   end

   always @(negedge clok) if (bus.sram_wri === 1'b1 && bus.sram_rd === 1'b1) overlap++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clok);
      #1;
   endtask

   task automatic wait_clear();
`ifdef SRAM_ARB_CLEAR_EN
      int k = 0;
      while (bus.busy === 1'b1 && k < 20) begin cyc(); k++; end
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL clear_timeout: busy=%b exp 0", bus.busy); else n_pass++;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      cyc(); cyc();
      n_chk++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) $display("FAIL rst_gnt: got %b%b exp 00", bus.gnt1, bus.gnt0); else n_pass++;
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) $display("FAIL rst_rvalid: got %b%b exp 00", bus.rvalid1, bus.rvalid0); else n_pass++;
      n_chk++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) $display("FAIL rst_rdata: got %h %h exp 00 00", bus.rdata0, bus.rdata1); else n_pass++;
      n_chk++; if (bus.sram_rd !== 1'b0) $display("FAIL rst_rd: got %b exp 0", bus.sram_rd); else n_pass++;
`ifdef SRAM_ARB_CLEAR_EN
      n_chk++; if (bus.busy !== 1'b1) $display("FAIL rst_busy: got %b exp 1", bus.busy); else n_pass++;
`else
      n_chk++; if (bus.sram_wri !== 1'b0) $display("FAIL rst_wri: got %b exp 0", bus.sram_wri); else n_pass++;
      n_chk++; if (bus.sram_add !== 3'd0 || bus.sram_din !== 8'h00) $display("FAIL rst_addr_din: got %h %h exp 0 00", bus.sram_add, bus.sram_din); else n_pass++;
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", bus.busy); else n_pass++;
`endif
      rst = 1'b0;
      wait_clear();
   endtask

   task automatic test_write_read();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd3; bus.wdata0 = 8'hD2;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) $display("FAIL wr_gnt: got %b%b exp 01", bus.gnt1, bus.gnt0); else n_pass++;
      n_chk++; if (bus.sram_wri !== 1'b1 || bus.sram_rd !== 1'b0) $display("FAIL wr_strobe: got wri=%b rd=%b exp 1 0", bus.sram_wri, bus.sram_rd); else n_pass++;
      n_chk++; if (bus.sram_add !== 3'd3 || bus.sram_din !== 8'hD2) $display("FAIL wr_bus: got %h %h exp 3 d2", bus.sram_add, bus.sram_din); else n_pass++;
      bus.req0 = 0;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b0 || bus.sram_wri !== 1'b0) $display("FAIL wr_done: got gnt0=%b wri=%b exp 0 0", bus.gnt0, bus.sram_wri); else n_pass++;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd3;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1 || bus.sram_rd !== 1'b1 || bus.sram_wri !== 1'b0) $display("FAIL rd_access: got gnt0=%b rd=%b wri=%b exp 1 1 0", bus.gnt0, bus.sram_rd, bus.sram_wri); else n_pass++;
      n_chk++; if (bus.sram_add !== 3'd3) $display("FAIL rd_addr: got %h exp 3", bus.sram_add); else n_pass++;
      bus.req0 = 0;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0) $display("FAIL rd_resp: got rvalid0=%b gnt0=%b exp 0 0", bus.rvalid0, bus.gnt0); else n_pass++;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'hD2) $display("FAIL rd_data: got rvalid0=%b rdata0=%h exp 1 d2", bus.rvalid0, bus.rdata0); else n_pass++;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 8'hD2) $display("FAIL rd_hold: got rvalid0=%b rdata0=%h exp 0 d2", bus.rvalid0, bus.rdata0); else n_pass++;
   endtask

   task automatic test_contention();
      rst = 1'b1;
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd1; bus.wdata0 = 8'h11;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd2; bus.wdata1 = 8'h22;
      cyc();
      rst = 1'b0;
      wait_clear();
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) $display("FAIL ct_first: got %b%b exp 01", bus.gnt1, bus.gnt0); else n_pass++;
      n_chk++; if (bus.sram_add !== 3'd1 || bus.sram_din !== 8'h11) $display("FAIL ct_bus0: got %h %h exp 1 11", bus.sram_add, bus.sram_din); else n_pass++;
      bus.req0 = 0;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) $display("FAIL ct_gap: got %b%b exp 00", bus.gnt1, bus.gnt0); else n_pass++;
      cyc();
      n_chk++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) $display("FAIL ct_second: got %b%b exp 10", bus.gnt1, bus.gnt0); else n_pass++;
      n_chk++; if (bus.sram_add !== 3'd2 || bus.sram_din !== 8'h22 || bus.sram_wri !== 1'b1) $display("FAIL ct_bus1: got %h %h wri=%b exp 2 22 1", bus.sram_add, bus.sram_din, bus.sram_wri); else n_pass++;
      bus.req1 = 0;
      cyc();
      // read back both, issued together; pointer now favours requester 0
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd2;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) $display("FAIL ct_rd_gnt0: got %b%b exp 01", bus.gnt1, bus.gnt0); else n_pass++;
      bus.req0 = 0;
      cyc(); cyc();
      n_chk++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h11) $display("FAIL ct_rd0: got rvalid0=%b rdata0=%h exp 1 11", bus.rvalid0, bus.rdata0); else n_pass++;
      cyc();
      n_chk++; if (bus.gnt1 !== 1'b1) $display("FAIL ct_rd_gnt1: got %b exp 1", bus.gnt1); else n_pass++;
      bus.req1 = 0;
      cyc(); cyc();
      n_chk++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'h22) $display("FAIL ct_rd1: got rvalid1=%b rdata1=%h exp 1 22", bus.rvalid1, bus.rdata1); else n_pass++;
      cyc();
   endtask

   task automatic test_fairness();
      int seq [4];
      int ng = 0;
      int k = 0;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd2;
      while (ng < 4 && k < 40) begin
         cyc(); k++;
         n_chk++; if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) $display("FAIL rr_dual_gnt: got 11 exp one-hot"); else n_pass++;
         if (bus.rvalid0 === 1'b1) begin
            n_chk++; if (bus.rdata0 !== 8'h11) $display("FAIL rr_rdata0: got %h exp 11", bus.rdata0); else n_pass++;
         end
         if (bus.rvalid1 === 1'b1) begin
            n_chk++; if (bus.rdata1 !== 8'h22) $display("FAIL rr_rdata1: got %h exp 22", bus.rdata1); else n_pass++;
         end
         if (bus.gnt0 === 1'b1) begin seq[ng] = 0; ng++; end
         else if (bus.gnt1 === 1'b1) begin seq[ng] = 1; ng++; end
      end
      bus.req0 = 0; bus.req1 = 0;
      n_chk++; if (ng != 4) $display("FAIL rr_count: got %0d grants exp 4", ng); else n_pass++;
      for (int i = 0; i < ng; i++) begin
         n_chk++; if (seq[i] != (i % 2)) $display("FAIL rr_order[%0d]: got %0d exp %0d", i, seq[i], i % 2); else n_pass++;
      end
      cyc(); cyc(); cyc();
   endtask

   task automatic test_read_routing();
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd7; bus.wdata1 = 8'hA5;
      cyc();
      n_chk++; if (bus.gnt1 !== 1'b1 || bus.sram_add !== 3'd7 || bus.sram_din !== 8'hA5) $display("FAIL rt_wr: got gnt1=%b add=%h din=%h exp 1 7 a5", bus.gnt1, bus.sram_add, bus.sram_din); else n_pass++;
      bus.req1 = 0;
      cyc();
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd7;
      cyc();
      bus.req1 = 0;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) $display("FAIL rt_resp: got %b%b exp 00", bus.rvalid1, bus.rvalid0); else n_pass++;
      cyc();
      n_chk++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'hA5) $display("FAIL rt_rd1: got rvalid1=%b rdata1=%h exp 1 a5", bus.rvalid1, bus.rdata1); else n_pass++;
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 8'h11) $display("FAIL rt_side0: got rvalid0=%b rdata0=%h exp 0 11", bus.rvalid0, bus.rdata0); else n_pass++;
      cyc();
   endtask

   task automatic test_reset_mid_read();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd3;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1) $display("FAIL mr_gnt: got %b exp 1", bus.gnt0); else n_pass++;
      bus.req0 = 0;
      cyc();
      rst = 1'b1;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) $display("FAIL mr_rvalid: got %b%b exp 00", bus.rvalid1, bus.rvalid0); else n_pass++;
      n_chk++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) $display("FAIL mr_rdata: got %h %h exp 00 00", bus.rdata0, bus.rdata1); else n_pass++;
      n_chk++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.sram_rd !== 1'b0) $display("FAIL mr_ctl: got gnt=%b%b rd=%b exp 00 0", bus.gnt1, bus.gnt0, bus.sram_rd); else n_pass++;
`ifndef SRAM_ARB_CLEAR_EN
      n_chk++; if (bus.sram_wri !== 1'b0 || bus.sram_add !== 3'd0 || bus.sram_din !== 8'h00) $display("FAIL mr_sram: got wri=%b add=%h din=%h exp 0 0 00", bus.sram_wri, bus.sram_add, bus.sram_din); else n_pass++;
`endif
      rst = 1'b0;
      cyc();
      n_chk++; if (bus.rvalid0 !== 1'b0) $display("FAIL mr_late: got rvalid0=%b exp 0", bus.rvalid0); else n_pass++;
      wait_clear();
   endtask

`ifdef SRAM_ARB_CLEAR_EN
   task automatic test_clear();
      rst = 1'b1;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd5;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_chk++; if (bus.busy !== 1'b1 || bus.sram_wri !== 1'b1 || bus.sram_rd !== 1'b0) $display("FAIL clr_ctl[%0d]: got busy=%b wri=%b rd=%b exp 1 1 0", i, bus.busy, bus.sram_wri, bus.sram_rd); else n_pass++;
         n_chk++; if (bus.sram_add !== 3'(i) || bus.sram_din !== 8'h00) $display("FAIL clr_bus[%0d]: got %h %h exp %0d 00", i, bus.sram_add, bus.sram_din, i); else n_pass++;
         n_chk++; if (bus.gnt0 !== 1'b0) $display("FAIL clr_gnt[%0d]: got %b exp 0", i, bus.gnt0); else n_pass++;
         cyc();
      end
      n_chk++; if (bus.busy !== 1'b0 || bus.gnt0 !== 1'b0) $display("FAIL clr_end: got busy=%b gnt0=%b exp 0 0", bus.busy, bus.gnt0); else n_pass++;
      cyc();
      n_chk++; if (bus.gnt0 !== 1'b1 || bus.sram_rd !== 1'b1 || bus.sram_add !== 3'd5) $display("FAIL clr_gnt: got gnt0=%b rd=%b add=%h exp 1 1 5", bus.gnt0, bus.sram_rd, bus.sram_add); else n_pass++;
      bus.req0 = 0;
      cyc(); cyc();
      n_chk++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h00) $display("FAIL clr_rd: got rvalid0=%b rdata0=%h exp 1 00", bus.rvalid0, bus.rdata0); else n_pass++;
      cyc();
   endtask
`endif

   initial begin
      rst = 1'b1;
      test_reset();
      test_write_read();
      test_contention();
      test_fairness();
      test_read_routing();
      test_reset_mid_read();
`ifdef SRAM_ARB_CLEAR_EN
      test_clear();
`endif
      n_chk++; if (overlap != 0) $display("FAIL wri_rd_overlap: got %0d cycles exp 0", overlap); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
